uart_rx_cfg_ctrl: RTL and testbench
===================================

# uart_rx_cfg_ctrl

Configuration and status controller for the UART receiver. It accepts host requests to change prescale and parity settings and applies them only at a frame boundary, briefly holding the line idle so the RX FSM never sees a mid-frame change. It also keeps saturating counters for good frames, parity errors and stop errors. It sits between the host register interface and the RX FSM, sampler and checker configuration inputs.

## Interface
- PRESCALE_DEFAULT, 8: prescale applied after reset; must be 8, 16 or 32.
- PAR_EN_DEFAULT, 1: parity enable applied after reset.
- CNT_WIDTH, 8: width of each status counter.

- CLK  in  1  single clock.
- RST  in  1  synchronous, active-high reset.
- cfg_req  in  1  host configuration request, level; held until cfg_ack or cfg_rej.
- cfg_prescale  in  6  requested prescale.
- cfg_par_en  in  1  requested parity enable.
- cfg_par_typ  in  1  requested parity type (0 even, 1 odd).
- rx_busy  in  1  RX FSM `enable`; high while a frame is in progress.
- data_valid  in  1  RX frame-good pulse.
- frame_end  in  1  one-cycle pulse in the RX error-check state.
- par_err  in  1  parity checker error.
- stp_err  in  1  stop checker error.
- clr_cnt  in  1  clear all counters.
- cfg_ack  out  1  one-cycle pulse: the request was applied.
- cfg_rej  out  1  one-cycle pulse: the request was rejected.
- rx_hold  out  1  forces the RX_IN seen by the RX FSM high.
- prescale  out  6  active prescale.
- PAR_EN  out  1  active parity enable.
- PAR_TYP  out  1  active parity type.
- frame_cnt  out  CNT_WIDTH  good-frame count.
- par_err_cnt  out  CNT_WIDTH  parity-error count.
- stp_err_cnt  out  CNT_WIDTH  stop-error count.

## Operation
- State machine states: RUN, PEND, HOLD, DONE. Reset state is RUN.
- RUN:
  - If cfg_req=1, latch cfg_prescale, cfg_par_en and cfg_par_typ into shadow registers.
  - A prescale other than 8, 16 or 32 is invalid: go to DONE with the reject flag set.
  - Otherwise go to PEND.
- PEND: rx_hold=0. When rx_busy=0, go to HOLD.
- HOLD: rx_hold=1 for exactly 2 cycles. A 1-bit counter tracks the cycles.
  - If rx_busy=1 in the first HOLD cycle (a frame started on the same edge), return to PEND and release rx_hold.
  - At the end of the second cycle, copy the shadow registers into prescale, PAR_EN and PAR_TYP, then go to DONE.
- DONE:
  - Exactly one of cfg_ack or cfg_rej is high, for this cycle only.
  - rx_hold=0.
  - cfg_req is ignored.
  - Always return to RUN.
- The active configuration changes only on the HOLD→DONE edge.
- Counters:
  - frame_cnt increments on data_valid.
  - par_err_cnt increments on frame_end & par_err.
  - stp_err_cnt increments on frame_end & stp_err.
  - Two counters may increment on the same cycle.
  - Each counter saturates at all-ones.
  - clr_cnt has priority over any increment on the same cycle.
- Reset values:
  - prescale=PRESCALE_DEFAULT, PAR_EN=PAR_EN_DEFAULT, PAR_TYP=0.
  - All counters 0.
  - cfg_ack, cfg_rej and rx_hold all 0.
  - Shadow registers set to the active defaults.
- RST mid-request (PEND or HOLD):
  - Return to RUN, drop rx_hold, emit no ack.
  - The active configuration reverts to the defaults.
  - The host must re-issue the request.

## Timing
- All outputs are registered.
- Invalid request: cfg_rej is high in cycle T+1, where cfg_req was first sampled high in cycle T.
- Valid request with rx_busy=0: PEND at T+1, HOLD at T+2 and T+3, new config and cfg_ack visible at T+4. Minimum latency is 4 cycles.
- Each additional cycle of rx_busy in PEND adds one cycle of latency. There is no timeout.
- The host deasserts cfg_req in the cycle after it sees ack or rej. DONE guarantees a held cfg_req is not re-accepted.
- Counters update one cycle after the qualifying input is sampled.

## Test plan
- Reset, then idle: prescale=8, PAR_EN=1, PAR_TYP=0, all counters 0, ack/rej/hold 0.
- Request prescale=16, par_en=0 with rx_busy=0 → rx_hold high for 2 cycles, then prescale=16, PAR_EN=0 and a single cfg_ack pulse 4 cycles after the request.
- Request prescale=12 → cfg_rej at T+1, configuration unchanged, no rx_hold.
- Request while rx_busy=1 for 20 cycles → config unchanged and rx_hold=0 throughout; applied and acked 3 cycles after rx_busy falls. Then raise rx_busy in the first HOLD cycle → returns to PEND, and the ack arrives only after a later idle.
- Counter saturation with CNT_WIDTH=8: apply 260 data_valid pulses → frame_cnt=255. Then clr_cnt together with data_valid → frame_cnt=0.
- RST asserted in the second HOLD cycle → RUN, rx_hold=0, no ack, prescale=8 afterward.

Source files
------------

// File: rtl/uart_rx_cfg_ctrl.sv
// UART receiver configuration/status controller: applies host prescale/parity
// changes only between frames and keeps saturating frame/error counters.
module uart_rx_cfg_ctrl #(
    parameter int unsigned PRESCALE_DEFAULT = 8,
    parameter logic        PAR_EN_DEFAULT   = 1'b1,
    parameter int unsigned CNT_WIDTH        = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 cfg_req,
    input  logic [5:0]           cfg_prescale,
    input  logic                 cfg_par_en,
    input  logic                 cfg_par_typ,
    input  logic                 rx_busy,
    input  logic                 data_valid,
    input  logic                 frame_end,
    input  logic                 par_err,
    input  logic                 stp_err,
    input  logic                 clr_cnt,
    output logic                 cfg_ack,
    output logic                 cfg_rej,
    output logic                 rx_hold,
    output logic [5:0]           prescale,
    output logic                 PAR_EN,
    output logic                 PAR_TYP,
    output logic [CNT_WIDTH-1:0] frame_cnt,
    output logic [CNT_WIDTH-1:0] par_err_cnt,
    output logic [CNT_WIDTH-1:0] stp_err_cnt
);

    localparam logic [1:0] RUN  = 2'd0;
    localparam logic [1:0] PEND = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [5:0] PRESCALE_RST = 6'(PRESCALE_DEFAULT);

    logic [1:0] state;
    logic       hold_cnt;
    logic [5:0] shadow_prescale;
    logic       shadow_par_en;
    logic       shadow_par_typ;
    logic       req_valid;

    assign req_valid = (cfg_prescale == 6'd8) || (cfg_prescale == 6'd16) ||
                       (cfg_prescale == 6'd32);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state           <= RUN;
            hold_cnt        <= 1'b0;
            rx_hold         <= 1'b0;
            cfg_ack         <= 1'b0;
            cfg_rej         <= 1'b0;
            shadow_prescale <= PRESCALE_RST;
            shadow_par_en   <= PAR_EN_DEFAULT;
            shadow_par_typ  <= 1'b0;
            prescale        <= PRESCALE_RST;
            PAR_EN          <= PAR_EN_DEFAULT;
            PAR_TYP         <= 1'b0;
        end else begin
            cfg_ack <= 1'b0;
            cfg_rej <= 1'b0;
            case (state)
                RUN: begin
                    if (cfg_req) begin
                        shadow_prescale <= cfg_prescale;
                        shadow_par_en   <= cfg_par_en;
                        shadow_par_typ  <= cfg_par_typ;
                        if (req_valid) begin
                            state <= PEND;
                        end else begin
                            state   <= DONE;
                            cfg_rej <= 1'b1;
                        end
                    end
                end
                PEND: begin
                    rx_hold <= 1'b0;
                    if (!rx_busy) begin
                        state    <= HOLD;
                        rx_hold  <= 1'b1;
                        hold_cnt <= 1'b0;
                    end
                end
                HOLD: begin
                    // A frame starting on the HOLD entry edge wins; retry from PEND.
                    if (!hold_cnt) begin
                        if (rx_busy) begin
                            state   <= PEND;
                            rx_hold <= 1'b0;
                        end else begin
                            hold_cnt <= 1'b1;
                        end
                    end else begin
                        prescale <= shadow_prescale;
                        PAR_EN   <= shadow_par_en;
                        PAR_TYP  <= shadow_par_typ;
                        rx_hold  <= 1'b0;
                        cfg_ack  <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    rx_hold <= 1'b0;
                    state   <= RUN;
                end
                default: begin
                    rx_hold <= 1'b0;
                    state   <= RUN;
                end
            endcase
        end
    end

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                     input logic en);
        if (en && !(&v)) begin
            return v + CNT_WIDTH'(1);
        end
        return v;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST || clr_cnt) begin
            frame_cnt   <= '0;
            par_err_cnt <= '0;
            stp_err_cnt <= '0;
        end else begin
            frame_cnt   <= sat_inc(frame_cnt, data_valid);
            par_err_cnt <= sat_inc(par_err_cnt, frame_end & par_err);
            stp_err_cnt <= sat_inc(stp_err_cnt, frame_end & stp_err);
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg_ctrl.sv
// Bench for uart_rx_cfg_ctrl: config responses are scoreboarded, counters and
// rx_hold are checked against a small bench-side model.
module tb_uart_rx_cfg_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       cfg_req = 1'b0;
    logic [5:0] cfg_prescale = '0;
    logic       cfg_par_en = 1'b0;
    logic       cfg_par_typ = 1'b0;
    logic       rx_busy = 1'b0;
    logic       data_valid = 1'b0;
    logic       frame_end = 1'b0;
    logic       par_err = 1'b0;
    logic       stp_err = 1'b0;
    logic       clr_cnt = 1'b0;
    logic       cfg_ack;
    logic       cfg_rej;
    logic       rx_hold;
    logic [5:0] prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] frame_cnt;
    logic [7:0] par_err_cnt;
    logic [7:0] stp_err_cnt;

    uart_rx_cfg_ctrl #(
        .PRESCALE_DEFAULT(8),
        .PAR_EN_DEFAULT  (1'b1),
        .CNT_WIDTH       (8)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .cfg_req     (cfg_req),
        .cfg_prescale(cfg_prescale),
        .cfg_par_en  (cfg_par_en),
        .cfg_par_typ (cfg_par_typ),
        .rx_busy     (rx_busy),
        .data_valid  (data_valid),
        .frame_end   (frame_end),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .clr_cnt     (clr_cnt),
        .cfg_ack     (cfg_ack),
        .cfg_rej     (cfg_rej),
        .rx_hold     (rx_hold),
        .prescale    (prescale),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .frame_cnt   (frame_cnt),
        .par_err_cnt (par_err_cnt),
        .stp_err_cnt (stp_err_cnt)
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    typedef struct {
        logic        ack;
        logic [5:0]  p;
        logic        pe;
        logic        pt;
        int unsigned due;
    } resp_t;

    resp_t sb[$];
    resp_t e;

    // Every ack/rej pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (cfg_ack || cfg_rej) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 32'(cfg_ack | cfg_rej), 32'(0));
            end else begin
                e = sb.pop_front();
                check("resp_ack", 32'(cfg_ack), 32'(e.ack));
                check("resp_rej", 32'(cfg_rej), 32'(!e.ack));
                check("resp_cycle", 32'(cyc), 32'(e.due));
                check("resp_prescale", 32'(prescale), 32'(e.p));
                check("resp_par_en", 32'(PAR_EN), 32'(e.pe));
                check("resp_par_typ", 32'(PAR_TYP), 32'(e.pt));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_req(input logic [5:0] p, input logic pe, input logic pt);
        cfg_prescale = p;
        cfg_par_en   = pe;
        cfg_par_typ  = pt;
        cfg_req      = 1'b1;
    endtask

    task automatic wait_resp();
        for (int i = 0; i < 12; i++) begin
            step();
            if (cfg_ack || cfg_rej) begin
                cfg_req = 1'b0;
                return;
            end
        end
        cfg_req = 1'b0;
        check("resp_timeout", 32'(0), 32'(1));
    endtask

    int unsigned t0;
    int unsigned m_frame, m_par, m_stp;
    logic [2:0] ev_tbl [6];

    initial begin
        m_frame = 0; m_par = 0; m_stp = 0;
        repeat (3) step();
        RST = 1'b0;
        step();

        check("rst_prescale", 32'(prescale), 32'(8));
        check("rst_par_en", 32'(PAR_EN), 32'(1));
        check("rst_par_typ", 32'(PAR_TYP), 32'(0));
        check("rst_frame_cnt", 32'(frame_cnt), 32'(0));
        check("rst_par_cnt", 32'(par_err_cnt), 32'(0));
        check("rst_stp_cnt", 32'(stp_err_cnt), 32'(0));
        check("rst_ack", 32'(cfg_ack), 32'(0));
        check("rst_rej", 32'(cfg_rej), 32'(0));
        check("rst_hold", 32'(rx_hold), 32'(0));

        // Valid request on an idle line: hold in T+2,T+3, ack at T+4.
        t0 = cyc;
        drive_req(6'd16, 1'b0, 1'b1);
        sb.push_back('{ack: 1'b1, p: 6'd16, pe: 1'b0, pt: 1'b1, due: t0 + 4});
        for (int i = 1; i <= 4; i++) begin
            step();
            check("hold_normal", 32'(rx_hold), 32'((i == 2) || (i == 3)));
            if (i < 4) check("cfg_stable", 32'(prescale), 32'(8));
        end
        cfg_req = 1'b0;
        step();
        check("hold_after_ack", 32'(rx_hold), 32'(0));

        // Invalid prescales are rejected on the next cycle with no hold.
        t0 = cyc;
        drive_req(6'd12, 1'b1, 1'b0);
        sb.push_back('{ack: 1'b0, p: 6'd16, pe: 1'b0, pt: 1'b1, due: t0 + 1});
        step();
        check("hold_rej", 32'(rx_hold), 32'(0));
        cfg_req = 1'b0;
        step();
        check("hold_rej2", 32'(rx_hold), 32'(0));
        t0 = cyc;
        drive_req(6'd33, 1'b1, 1'b1);
        sb.push_back('{ack: 1'b0, p: 6'd16, pe: 1'b0, pt: 1'b1, due: t0 + 1});
        wait_resp();
        step();

        // Busy line: request waits in PEND, applied 3 cycles after busy falls.
        rx_busy = 1'b1;
        drive_req(6'd32, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            check("busy_hold", 32'(rx_hold), 32'(0));
            check("busy_cfg", 32'(prescale), 32'(16));
        end
        rx_busy = 1'b0;
        t0 = cyc;
        sb.push_back('{ack: 1'b1, p: 6'd32, pe: 1'b1, pt: 1'b0, due: t0 + 3});
        wait_resp();
        step();

        // Frame starts in the first HOLD cycle: back to PEND, hold released.
        t0 = cyc;
        drive_req(6'd8, 1'b0, 1'b0);
        step();
        check("abort_pend_hold", 32'(rx_hold), 32'(0));
        step();
        check("abort_hold1", 32'(rx_hold), 32'(1));
        rx_busy = 1'b1;
        step();
        check("abort_released", 32'(rx_hold), 32'(0));
        for (int i = 0; i < 4; i++) begin
            step();
            check("abort_wait_hold", 32'(rx_hold), 32'(0));
            check("abort_wait_cfg", 32'(prescale), 32'(32));
        end
        rx_busy = 1'b0;
        t0 = cyc;
        sb.push_back('{ack: 1'b1, p: 6'd8, pe: 1'b0, pt: 1'b0, due: t0 + 3});
        wait_resp();
        step();

        // Error counters: {frame_end, par_err, stp_err}.
        ev_tbl[0] = 3'b110; ev_tbl[1] = 3'b101; ev_tbl[2] = 3'b111;
        ev_tbl[3] = 3'b100; ev_tbl[4] = 3'b011; ev_tbl[5] = 3'b110;
        for (int i = 0; i < 6; i++) begin
            frame_end = ev_tbl[i][2];
            par_err   = ev_tbl[i][1];
            stp_err   = ev_tbl[i][0];
            if (ev_tbl[i][2] && ev_tbl[i][1]) m_par++;
            if (ev_tbl[i][2] && ev_tbl[i][0]) m_stp++;
            step();
            check("par_err_cnt", 32'(par_err_cnt), 32'(m_par));
            check("stp_err_cnt", 32'(stp_err_cnt), 32'(m_stp));
        end
        frame_end = 1'b0; par_err = 1'b0; stp_err = 1'b0;

        // frame_cnt saturates at 255 after 260 pulses.
        data_valid = 1'b1;
        for (int i = 0; i < 260; i++) begin
            step();
            if (m_frame < 255) m_frame++;
            if (i == 0 || i == 253 || i == 254 || i == 259)
                check("frame_cnt", 32'(frame_cnt), 32'(m_frame));
        end
        clr_cnt = 1'b1;
        step();
        check("clr_frame", 32'(frame_cnt), 32'(0));
        check("clr_par", 32'(par_err_cnt), 32'(0));
        check("clr_stp", 32'(stp_err_cnt), 32'(0));
        clr_cnt = 1'b0;
        step();
        check("frame_after_clr", 32'(frame_cnt), 32'(1));
        data_valid = 1'b0;
        step();

        // Reset in the second HOLD cycle: no ack, defaults restored.
        drive_req(6'd32, 1'b1, 1'b1);
        step();
        step();
        step();
        check("rst_hold2", 32'(rx_hold), 32'(1));
        RST = 1'b1;
        cfg_req = 1'b0;
        step();
        check("midrst_hold", 32'(rx_hold), 32'(0));
        check("midrst_ack", 32'(cfg_ack), 32'(0));
        check("midrst_prescale", 32'(prescale), 32'(8));
        check("midrst_par_en", 32'(PAR_EN), 32'(1));
        check("midrst_par_typ", 32'(PAR_TYP), 32'(0));
        check("midrst_frame_cnt", 32'(frame_cnt), 32'(0));
        RST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("post_rst_hold", 32'(rx_hold), 32'(0));
        end

        t0 = cyc;
        drive_req(6'd32, 1'b1, 1'b1);
        sb.push_back('{ack: 1'b1, p: 6'd32, pe: 1'b1, pt: 1'b1, due: t0 + 4});
        wait_resp();

        repeat (4) step();
        check("sb_empty", 32'(sb.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
